// File: rtl/iir_servo_sequencer_if.sv
// Host configuration bus for the IIR servo sequencer: coefficient writes plus commit strobe.
interface iir_servo_sequencer_if #(
    parameter int COEF_WIDTH = 35
);
    logic                         cfg_valid_in;
    logic                         cfg_ready_out;
    logic [1:0]                   cfg_sel_in;
    logic signed [COEF_WIDTH-1:0] cfg_data_in;
    logic                         commit_in;

    modport master (
        output cfg_valid_in,
        output cfg_sel_in,
        output cfg_data_in,
        output commit_in,
        input  cfg_ready_out
    );

    modport slave (
        input  cfg_valid_in,
        input  cfg_sel_in,
        input  cfg_data_in,
        input  commit_in,
        output cfg_ready_out
    );
endinterface

// File: rtl/iir_servo_sequencer.sv
// Sequences on/hold for a first-order anti-windup IIR servo, commits shadowed
// coefficients atomically behind a pipeline flush, and relocks after a sustained rail.
//
// state  | meaning
// IDLE   | servo off; a pending commit is applied here directly
// FLUSH  | on_out low for FLUSH_CYCLES so the filter pipeline drains
// RUN    | filter running; rail timer active
// HOLD   | filter running with integrator frozen
// RELOCK | on_out low for RELOCK_CYCLES after a rail timeout
module iir_servo_sequencer #(
    parameter int COEF_WIDTH    = 35,
    parameter int FLUSH_CYCLES  = 4,
    parameter int RAIL_TIMEOUT  = 1000000,
    parameter int RELOCK_CYCLES = 1024,
    parameter int AUTO_RELOCK   = 1,
    parameter int CNT_WIDTH     = 24
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    iir_servo_sequencer_if.slave         cfg,
    input  logic                         enable_in,
    input  logic                         hold_req_in,
    input  logic [1:0]                   railed_in,
    output logic                         on_out,
    output logic                         hold_out,
    output logic signed [COEF_WIDTH-1:0] a1_out,
    output logic signed [COEF_WIDTH-1:0] b0_out,
    output logic signed [COEF_WIDTH-1:0] b1_out,
    output logic [2:0]                   state_out,
    output logic [15:0]                  relock_count_out
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_RUN    = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RELOCK = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] FLUSH_LOAD  = CNT_WIDTH'(FLUSH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RELOCK_LOAD = CNT_WIDTH'(RELOCK_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RAIL_LAST   = CNT_WIDTH'(RAIL_TIMEOUT - 1);
    localparam logic                 RELOCK_EN   = (AUTO_RELOCK != 0);

    state_t                       state_q, state_d;
    logic [CNT_WIDTH-1:0]         timer_q, timer_d;
    logic [CNT_WIDTH-1:0]         rail_q, rail_d;
    logic                         pending_q, pending_d;
    logic                         ready_q, ready_d;
    logic                         on_q, on_d;
    logic                         hold_q, hold_d;
    logic [15:0]                  relock_q, relock_d;
    logic signed [COEF_WIDTH-1:0] sh_a1_q, sh_a1_d, sh_b0_q, sh_b0_d, sh_b1_q, sh_b1_d;
    logic signed [COEF_WIDTH-1:0] a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;

    logic wr_en;
    logic copy_en;
    logic railed;
    logic rail_hit;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        rail_d    = '0;
        pending_d = pending_q;
        relock_d  = relock_q;
        sh_a1_d   = sh_a1_q;
        sh_b0_d   = sh_b0_q;
        sh_b1_d   = sh_b1_q;
        a1_d      = a1_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        copy_en   = 1'b0;

        wr_en    = cfg.cfg_valid_in & ready_q;
        railed   = (railed_in != 2'b00);
        rail_hit = RELOCK_EN && railed && (rail_q == RAIL_LAST);

        // Sel 3 is accepted but has nowhere to land.
        if (wr_en) begin
            case (cfg.cfg_sel_in)
                2'd0:    sh_a1_d = cfg.cfg_data_in;
                2'd1:    sh_b0_d = cfg.cfg_data_in;
                2'd2:    sh_b1_d = cfg.cfg_data_in;
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                copy_en = pending_q;
                if (enable_in) begin
                    state_d = ST_FLUSH;
                    timer_d = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (!enable_in)
                    state_d = ST_IDLE;
                else if (timer_q == '0)
                    state_d = ST_RUN;
                else
                    timer_d = timer_q - CNT_WIDTH'(1);
            end
            ST_RUN: begin
                if (!enable_in) begin
                    state_d = ST_IDLE;
                end else if (pending_q) begin
                    state_d = ST_FLUSH;
                    timer_d = FLUSH_LOAD;
                    copy_en = 1'b1;
                end else if (rail_hit) begin
                    state_d  = ST_RELOCK;
                    timer_d  = RELOCK_LOAD;
                    relock_d = (relock_q == 16'hFFFF) ? relock_q : relock_q + 16'd1;
                end else if (hold_req_in) begin
                    state_d = ST_HOLD;
                end else if (railed) begin
                    // Saturate at the last count so a disabled relock never wraps.
                    rail_d = (rail_q == RAIL_LAST) ? rail_q : rail_q + CNT_WIDTH'(1);
                end
            end
            ST_HOLD: begin
                if (!enable_in) begin
                    state_d = ST_IDLE;
                end else if (pending_q) begin
                    state_d = ST_FLUSH;
                    timer_d = FLUSH_LOAD;
                    copy_en = 1'b1;
                end else if (!hold_req_in) begin
                    state_d = ST_RUN;
                end
            end
            ST_RELOCK: begin
                if (!enable_in) begin
                    state_d = ST_IDLE;
                end else if (timer_q == '0) begin
                    state_d = ST_FLUSH;
                    timer_d = FLUSH_LOAD;
                end else begin
                    timer_d = timer_q - CNT_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Copy only happens with pending already set, so it never races a new commit.
        if (copy_en) begin
            a1_d      = sh_a1_q;
            b0_d      = sh_b0_q;
            b1_d      = sh_b1_q;
            pending_d = 1'b0;
        end else if (cfg.commit_in && !pending_q) begin
            pending_d = 1'b1;
        end

        ready_d = ~pending_d;
        on_d    = (state_d == ST_RUN) || (state_d == ST_HOLD);
        hold_d  = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            rail_q    <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b0;
            on_q      <= 1'b0;
            hold_q    <= 1'b0;
            relock_q  <= '0;
            sh_a1_q   <= '0;
            sh_b0_q   <= '0;
            sh_b1_q   <= '0;
            a1_q      <= '0;
            b0_q      <= '0;
            b1_q      <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            rail_q    <= rail_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            on_q      <= on_d;
            hold_q    <= hold_d;
            relock_q  <= relock_d;
            sh_a1_q   <= sh_a1_d;
            sh_b0_q   <= sh_b0_d;
            sh_b1_q   <= sh_b1_d;
            a1_q      <= a1_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
        end
    end

    assign cfg.cfg_ready_out = ready_q;
    assign on_out            = on_q;
    assign hold_out          = hold_q;
    assign a1_out            = a1_q;
    assign b0_out            = b0_q;
    assign b1_out            = b1_q;
    assign state_out         = state_q;
    assign relock_count_out  = relock_q;

endmodule

// File: tb/tb_iir_servo_sequencer.sv
// Directed bench: dut_a relocks on rail timeout, dut_b has relock disabled; both share stimulus.
module tb_iir_servo_sequencer;

    localparam int CW = 35;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cfg_valid;
    logic [1:0]           cfg_sel;
    logic signed [CW-1:0] cfg_data;
    logic                 commit;
    logic                 enable;
    logic                 hold_req;
    logic [1:0]           railed;

    logic                 on_a, hold_a, on_b, hold_b;
    logic signed [CW-1:0] a1_a, b0_a, b1_a, a1_b, b0_b, b1_b;
    logic [2:0]           state_a, state_b;
    logic [15:0]          relock_a, relock_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iir_servo_sequencer_if #(.COEF_WIDTH(CW)) bus_a ();
    iir_servo_sequencer_if #(.COEF_WIDTH(CW)) bus_b ();

    assign bus_a.cfg_valid_in = cfg_valid;
    assign bus_a.cfg_sel_in   = cfg_sel;
    assign bus_a.cfg_data_in  = cfg_data;
    assign bus_a.commit_in    = commit;
    assign bus_b.cfg_valid_in = cfg_valid;
    assign bus_b.cfg_sel_in   = cfg_sel;
    assign bus_b.cfg_data_in  = cfg_data;
    assign bus_b.commit_in    = commit;

    iir_servo_sequencer #(
        .COEF_WIDTH(CW), .FLUSH_CYCLES(4), .RAIL_TIMEOUT(8),
        .RELOCK_CYCLES(6), .AUTO_RELOCK(1), .CNT_WIDTH(24)
    ) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .cfg(bus_a.slave),
        .enable_in(enable), .hold_req_in(hold_req), .railed_in(railed),
        .on_out(on_a), .hold_out(hold_a), .a1_out(a1_a), .b0_out(b0_a), .b1_out(b1_a),
        .state_out(state_a), .relock_count_out(relock_a)
    );

    iir_servo_sequencer #(
        .COEF_WIDTH(CW), .FLUSH_CYCLES(4), .RAIL_TIMEOUT(8),
        .RELOCK_CYCLES(6), .AUTO_RELOCK(0), .CNT_WIDTH(24)
    ) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .cfg(bus_b.slave),
        .enable_in(enable), .hold_req_in(hold_req), .railed_in(railed),
        .on_out(on_b), .hold_out(hold_b), .a1_out(a1_b), .b0_out(b0_b), .b1_out(b1_b),
        .state_out(state_b), .relock_count_out(relock_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic signed [CW-1:0] data);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_data  = data;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_sel = 2'd0; cfg_data = '0;
        commit = 1'b0; enable = 1'b0; hold_req = 1'b0; railed = 2'b00;
        repeat (3) step();
        chk("rst_state", 64'(state_a), 64'd0);
        chk("rst_on", 64'(on_a), 64'd0);
        chk("rst_ready", 64'(bus_a.cfg_ready_out), 64'd0);
        chk("rst_a1", 64'(a1_a), 64'd0);
        chk("rst_relock", 64'(relock_a), 64'd0);

        // 1: load 3/5/7, commit in IDLE, enable through FLUSH into RUN
        rst_n = 1'b1;
        step();
        chk("t1_ready_after_rst", 64'(bus_a.cfg_ready_out), 64'd1);
        wr(2'd0, 35'sd3);
        wr(2'd1, 35'sd5);
        wr(2'd2, 35'sd7);
        commit = 1'b1;
        step();
        commit = 1'b0;
        chk("t1_ready_pending", 64'(bus_a.cfg_ready_out), 64'd0);
        step();
        chk("t1_a1", 64'(a1_a), 64'd3);
        chk("t1_b0", 64'(b0_a), 64'd5);
        chk("t1_b1", 64'(b1_a), 64'd7);
        chk("t1_ready_back", 64'(bus_a.cfg_ready_out), 64'd1);
        chk("t1_idle_state", 64'(state_a), 64'd0);
        chk("t1_idle_on", 64'(on_a), 64'd0);
        enable = 1'b1;
        step();
        chk("t1_flush_state", 64'(state_a), 64'd1);
        chk("t1_flush_on", 64'(on_a), 64'd0);
        repeat (3) step();
        chk("t1_flush_last_state", 64'(state_a), 64'd1);
        chk("t1_flush_last_on", 64'(on_a), 64'd0);
        step();
        chk("t1_run_state", 64'(state_a), 64'd2);
        chk("t1_run_on", 64'(on_a), 64'd1);

        // 2: write b0=-9 together with commit while running; a blocked write must be dropped
        cfg_valid = 1'b1; cfg_sel = 2'd1; cfg_data = -35'sd9; commit = 1'b1;
        step();
        cfg_valid = 1'b0; commit = 1'b0;
        chk("t2_ready_pending", 64'(bus_a.cfg_ready_out), 64'd0);
        chk("t2_still_run", 64'(state_a), 64'd2);
        chk("t2_b0_not_yet", 64'(b0_a), 64'd5);
        cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_data = 35'sd99;
        step();
        cfg_valid = 1'b0;
        chk("t2_flush_state", 64'(state_a), 64'd1);
        chk("t2_flush_on", 64'(on_a), 64'd0);
        chk("t2_b0_new", 64'(b0_a), 64'(-35'sd9));
        chk("t2_a1_unchanged", 64'(a1_a), 64'd3);
        chk("t2_ready_back", 64'(bus_a.cfg_ready_out), 64'd1);
        repeat (3) step();
        chk("t2_flush_last", 64'(state_a), 64'd1);
        step();
        chk("t2_run_state", 64'(state_a), 64'd2);
        chk("t2_run_on", 64'(on_a), 64'd1);

        // 3: 7 railed, 1 clear, 8 railed -> relock on the 8th
        railed = 2'b10;
        repeat (7) step();
        chk("t3_no_relock_7", 64'(state_a), 64'd2);
        railed = 2'b00;
        step();
        railed = 2'b10;
        repeat (7) step();
        chk("t3_no_relock_2nd7", 64'(state_a), 64'd2);
        step();
        chk("t3_relock_state", 64'(state_a), 64'd4);
        chk("t3_relock_count", 64'(relock_a), 64'd1);
        chk("t3_relock_on", 64'(on_a), 64'd0);
        railed = 2'b00;
        for (int i = 1; i < 10; i++) begin
            step();
            chk("t3_off_window", 64'(on_a), 64'd0);
        end
        step();
        chk("t3_back_run", 64'(state_a), 64'd2);
        chk("t3_back_on", 64'(on_a), 64'd1);

        // 4: hold with sustained rail must not relock
        hold_req = 1'b1; railed = 2'b01;
        step();
        chk("t4_hold_state", 64'(state_a), 64'd3);
        chk("t4_hold_out", 64'(hold_a), 64'd1);
        chk("t4_hold_on", 64'(on_a), 64'd1);
        repeat (20) step();
        chk("t4_still_hold", 64'(state_a), 64'd3);
        chk("t4_no_relock", 64'(relock_a), 64'd1);
        railed = 2'b00; hold_req = 1'b0;
        step();
        chk("t4_release_state", 64'(state_a), 64'd2);
        chk("t4_release_hold", 64'(hold_a), 64'd0);

        // 5: drop enable mid-relock
        railed = 2'b10;
        repeat (8) step();
        chk("t5_relock_state", 64'(state_a), 64'd4);
        chk("t5_relock_count", 64'(relock_a), 64'd2);
        railed = 2'b00;
        repeat (2) step();
        enable = 1'b0;
        step();
        chk("t5_idle_state", 64'(state_a), 64'd0);
        chk("t5_idle_on", 64'(on_a), 64'd0);
        chk("t5_count_kept", 64'(relock_a), 64'd2);

        // 6: relock disabled on dut_b, then reset mid-RUN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_b_rst_state", 64'(state_b), 64'd0);
        step();
        wr(2'd0, 35'sd11);
        commit = 1'b1;
        step();
        commit = 1'b0;
        step();
        enable = 1'b1;
        repeat (5) step();
        chk("t6_b_run", 64'(state_b), 64'd2);
        chk("t6_b_a1", 64'(a1_b), 64'd11);
        railed = 2'b11;
        repeat (20) step();
        chk("t6_b_stays_run", 64'(state_b), 64'd2);
        chk("t6_b_on", 64'(on_b), 64'd1);
        chk("t6_b_no_relock", 64'(relock_b), 64'd0);
        chk("t6_a_relocked", 64'(relock_a), 64'd1);
        rst_n = 1'b0;
        step();
        chk("t6_b_rst_on", 64'(on_b), 64'd0);
        chk("t6_b_rst_hold", 64'(hold_b), 64'd0);
        chk("t6_b_rst_state2", 64'(state_b), 64'd0);
        chk("t6_b_rst_a1", 64'(a1_b), 64'd0);
        chk("t6_b_rst_ready", 64'(bus_b.cfg_ready_out), 64'd0);
        chk("t6_a_rst_state", 64'(state_a), 64'd0);
        chk("t6_a_rst_count", 64'(relock_a), 64'd0);
        rst_n = 1'b1; railed = 2'b00; enable = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
